hash_req_scheduler: RTL and testbench
=====================================

// Module: hash_req_scheduler
// PURPOSE
//  Shares one lightHashDES core between NUM_REQ requesters under round-robin arbitration.
//  Per job: latch the granted requester's length, stream its bytes into the core
//  (core_M_valid/core_M), wait for core_hash_ready, then return the 32-bit digest with a done pulse.
//  A watchdog aborts jobs whose core never reports ready.
//  Sits between the message sources and the single hash core instance.
// PARAMETERS
//  NUM_REQ    4     number of requesters (2..8)
//  LEN_W      64    message length width, matches core input_lenght
//  TIMEOUT    1024  max cycles in WAIT before abort
// PORTS
//  clk               in   1          system clock, all logic on posedge
//  rst_n             in   1          synchronous active-low reset
//  req               in   NUM_REQ    requester i wants a job; held until done_o[i]/err_o[i]
//  req_len           in   NUM_REQ*LEN_W  slice i = byte length of message i, stable while req[i]=1
//  req_byte          in   NUM_REQ*8  slice i = next message byte of requester i
//  req_byte_valid    in   NUM_REQ    slice i byte present
//  req_byte_ready    out  NUM_REQ    byte i accepted this cycle (only granted index may be 1)
//  grant             out  NUM_REQ    one-hot owner of the core, 0 when idle
//  done_o            out  NUM_REQ    1-cycle pulse: digest_o valid for that requester
//  err_o             out  NUM_REQ    1-cycle pulse: job aborted by watchdog
//  digest_o          out  32         captured digest, held until next capture
//  core_M_valid      out  1          to core M_valid
//  core_M            out  8          to core M
//  core_input_lenght out  LEN_W      to core input_lenght, stable for whole job
//  core_hash_ready   in   1          from core hash_ready
//  core_digest       in   32         from core digest
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE, all outputs 0, rr pointer=0, counters 0.
//  FSM: IDLE -> FEED -> WAIT -> RESP -> IDLE; WAIT -> ABORT -> IDLE on timeout.
//  IDLE: if any req, pick first set index at or after rr pointer (wrap at NUM_REQ);
//   register grant, core_input_lenght=req_len[g], remaining=req_len[g]; go FEED next cycle.
//   No req: stay IDLE, grant=0.
//  FEED, remaining>0: req_byte_ready[g]=req_byte_valid[g] (combinational);
//   on accept, core_M_valid=1, core_M=byte (registered, 1-cycle latency), remaining-=1.
//   Gaps allowed: no valid byte -> core_M_valid=0 that cycle.
//   Last byte accepted -> WAIT.
//  FEED, length 0: emit exactly one core_M_valid=1 cycle with core_M=0, no byte consumed -> WAIT.
//  WAIT: core_M_valid=0; watchdog counts cycles from entry.
//   core_hash_ready=1 is ignored on the first WAIT cycle (core needs >=1 cycle after last M_valid).
//   Thereafter: ready=1 -> digest_o<=core_digest, RESP.
//   Counter reaching TIMEOUT with no ready -> ABORT.
//  RESP: done_o[g]=1 for one cycle; rr pointer=g+1 mod NUM_REQ; grant cleared; -> IDLE.
//  ABORT: err_o[g]=1 for one cycle; digest_o unchanged; rr advances as in RESP; -> IDLE.
//  Requester drops req mid-job: job still completes, done_o/err_o still pulse; no early abort.
//  Requester with req_len>0 that never supplies bytes stalls FEED indefinitely;
//   watchdog covers WAIT only.
//  Simultaneous done and new req from the same requester: re-arbitrated in IDLE next cycle,
//   with lowest priority unless it is the only requester.
//  Min job latency (len L, no gaps): IDLE->done = 1 + L(+1 if L=0) + 2 + 1 cycles.
//  grant, req_byte_ready, done_o and err_o are always one-hot or zero.
//  remaining is LEN_W wide; no wrap (decrement only when >0).
// TESTING
//  1. Empty msg: req[0]=1, len=0 -> one core_M_valid pulse, M=0; done_o[0]; digest_o=32'hb4d92c3f.
//  2. One char: req[1]=1, len=1, byte 8'h41 -> single M_valid with M=8'h41; done_o[1];
//     digest_o=32'h4b76d630.
//  3. Fairness: req=4'b1111 held, len=1 each -> grant order 0,1,2,3,0; never two grants;
//     re-requests wait their turn.
//  4. Byte gaps: len=3, valid toggles 1,0,1,0,1 -> core_M_valid follows accepts, 3 pulses;
//     input_lenght=3 stable.
//  5. Timeout: TIMEOUT=8, core_hash_ready tied 0 -> err_o[g] pulse 8 cycles into WAIT;
//     digest_o unchanged; FSM back to IDLE.
//  6. Reset mid-FEED: rst_n=0 one posedge -> grant=0, core_M_valid=0, no done/err;
//     next req starts at index 0.

Source files
------------

// File: rtl/hash_req_scheduler.sv
// Round-robin scheduler sharing one hash core between requesters.
// Streams the granted message, waits for the digest, watchdog on WAIT.
module hash_req_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int LEN_W   = 64,
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*LEN_W-1:0] req_len,
   input  logic [NUM_REQ*8-1:0]     req_byte,
   input  logic [NUM_REQ-1:0]       req_byte_valid,
   output logic [NUM_REQ-1:0]       req_byte_ready,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       done_o,
   output logic [NUM_REQ-1:0]       err_o,
   output logic [31:0]              digest_o,
   output logic                     core_M_valid,
   output logic [7:0]               core_M,
   output logic [LEN_W-1:0]         core_input_lenght,
   input  logic                     core_hash_ready,
   input  logic [31:0]              core_digest
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FEED, S_WAIT, S_RESP, S_ABORT
   } state_t;

   state_t           state, state_nx;
   logic [IW-1:0]    rr, gidx, pick, g_next;
   logic             pick_ok;
   logic [LEN_W-1:0] remaining, pick_len;
   logic [CW-1:0]    wcnt;
   logic             accept, sel_valid;
   logic [7:0]       sel_byte;

   function automatic logic [NUM_REQ-1:0] oh(input logic [IW-1:0] i);
      oh    = '0;
      oh[i] = 1'b1;
   endfunction

   // First requester at or after the round-robin pointer
   always_comb begin : arb
      logic [IW:0] sum;
      pick    = '0;
      pick_ok = 1'b0;
      sum     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr} + (IW+1)'(k);
         if (sum >= (IW+1)'(NUM_REQ))
            sum = sum - (IW+1)'(NUM_REQ);
         if (!pick_ok && req[sum[IW-1:0]]) begin
            pick    = sum[IW-1:0];
            pick_ok = 1'b1;
         end
      end
      pick_len = req_len[int'(pick)*LEN_W +: LEN_W];
   end

   // Owner's byte lane, handshake and pointer advance
   always_comb begin
      sel_valid      = req_byte_valid[gidx];
      sel_byte       = req_byte[int'(gidx)*8 +: 8];
      accept         = (state == S_FEED) && (remaining != '0)
                       && sel_valid;
      req_byte_ready = accept ? oh(gidx) : '0;
      g_next         = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic; ready is ignored on the first WAIT cycle
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (pick_ok) state_nx = S_FEED;
         S_FEED: begin
            if (remaining == '0)
               state_nx = S_WAIT;
            else if (accept && remaining == LEN_W'(1))
               state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (wcnt != '0 && core_hash_ready)
               state_nx = S_RESP;
            else if (wcnt == CW'(TIMEOUT - 1))
               state_nx = S_ABORT;
         end
         S_RESP:  state_nx = S_IDLE;
         S_ABORT: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Registered outputs and job bookkeeping
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant             <= '0;
         gidx              <= '0;
         rr                <= '0;
         remaining         <= '0;
         wcnt              <= '0;
         done_o            <= '0;
         err_o             <= '0;
         digest_o          <= '0;
         core_M_valid      <= 1'b0;
         core_M            <= '0;
         core_input_lenght <= '0;
      end else begin
         done_o       <= '0;
         err_o        <= '0;
         core_M_valid <= 1'b0;
         core_M       <= '0;
         unique case (state)
            S_IDLE: begin
               if (pick_ok) begin
                  grant             <= oh(pick);
                  gidx              <= pick;
                  core_input_lenght <= pick_len;
                  remaining         <= pick_len;
               end
            end
            S_FEED: begin
               wcnt <= '0;
               if (remaining == '0) begin
                  core_M_valid <= 1'b1;
               end else if (accept) begin
                  core_M_valid <= 1'b1;
                  core_M       <= sel_byte;
                  remaining    <= remaining - 1'b1;
               end
            end
            S_WAIT: begin
               wcnt <= wcnt + 1'b1;
               if (state_nx == S_RESP) begin
                  digest_o <= core_digest;
                  done_o   <= oh(gidx);
               end
               if (state_nx == S_ABORT)
                  err_o <= oh(gidx);
            end
            S_RESP, S_ABORT: begin
               grant <= '0;
               rr    <= g_next;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hash_req_scheduler.sv
// Bench for hash_req_scheduler: directed jobs with a scoreboard
// monitor checking core bytes, completions and digests.
module tb_hash_req_scheduler;

   localparam int N  = 4;
   localparam int LW = 64;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*LW-1:0] req_len = '0;
   logic [N*8-1:0]  req_byte = '0;
   logic [N-1:0]    req_byte_valid = '0;
   logic [N-1:0]    req_byte_ready;
   logic [N-1:0]    grant, done_o, err_o;
   logic [31:0]     digest_o;
   logic            core_M_valid;
   logic [7:0]      core_M;
   logic [LW-1:0]   core_input_lenght;
   logic            core_en = 1'b1;
   logic [31:0]     cur_dig = '0;
   logic [31:0]     last_dig = '0;

   always #5 clk = ~clk;

   hash_req_scheduler #(.NUM_REQ(N), .LEN_W(LW), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len),
      .req_byte(req_byte), .req_byte_valid(req_byte_valid),
      .req_byte_ready(req_byte_ready), .grant(grant),
      .done_o(done_o), .err_o(err_o), .digest_o(digest_o),
      .core_M_valid(core_M_valid), .core_M(core_M),
      .core_input_lenght(core_input_lenght),
      .core_hash_ready(core_en), .core_digest(cur_dig)
   );

   typedef struct {bit err; int idx; logic [31:0] dig;} ev_t;
   typedef struct {logic [7:0] b; logic [LW-1:0] len;} mb_t;
   ev_t evq[$];
   mb_t mq[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (grant != '0) chk("grant_onehot", 64'($onehot(grant)), 1);
         if (core_M_valid) begin
            if (mq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_M got %h expected none", core_M);
            end else begin
               mb_t m;
               m = mq.pop_front();
               chk("core_M", core_M, m.b);
               chk("input_len", core_input_lenght, m.len);
            end
         end
         if ((done_o | err_o) != '0) begin
            if (evq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done got %b/%b expected none",
                        done_o, err_o);
            end else begin
               ev_t e;
               logic [N-1:0] g;
               e = evq.pop_front();
               g = '0;
               g[e.idx] = 1'b1;
               chk("done_vec", done_o, e.err ? '0 : g);
               chk("err_vec", err_o, e.err ? g : '0);
               chk("grant_at_done", grant, g);
               chk("digest", digest_o, e.dig);
            end
         end
      end
   end

   task automatic set_lane(input int i, input logic [LW-1:0] len,
                           input logic [7:0] b);
      req_len[i*LW +: LW] = len;
      req_byte[i*8 +: 8]  = b;
   endtask

   task automatic wait_fin(input int i, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(done_o[i] | err_o[i]) && cyc < 300);
      if (cyc >= 300) begin
         checks++; errors++;
         $display("FAIL wait_fin got none expected event %0d", i);
      end
   endtask

   task automatic run_job(input int i, input logic [LW-1:0] len,
                          input logic [7:0] b, input logic [31:0] dig,
                          input logic en, input bit err,
                          input int lat);
      int cyc;
      cur_dig = dig;
      core_en = en;
      mq.push_back('{(len == 0) ? 8'h00 : b, len});
      evq.push_back('{err, i, err ? last_dig : dig});
      if (!err) last_dig = dig;
      set_lane(i, len, b);
      req_byte_valid[i] = (len != 0);
      req[i] = 1'b1;
      wait_fin(i, cyc);
      chk("latency", cyc, lat);
      req[i] = 1'b0;
      req_byte_valid[i] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int n, cyc, k, t;
      logic [7:0] gd [3];
      gd[0] = 8'hC1; gd[1] = 8'hC2; gd[2] = 8'hC3;

      repeat (3) @(negedge clk);
      chk("rst_grant", grant, 0);
      chk("rst_done", done_o | err_o, 0);
      chk("rst_mvalid", core_M_valid, 0);
      chk("rst_digest", digest_o, 0);
      chk("rst_len", core_input_lenght, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // fairness: all four requesting, grants 0,1,2,3,0
      cur_dig = 32'hA5A50003;
      last_dig = cur_dig;
      for (int i = 0; i < 4; i++) set_lane(i, 1, 8'h10 + 8'(i));
      for (int j = 0; j < 5; j++) begin
         mq.push_back('{8'h10 + 8'(j % 4), 64'd1});
         evq.push_back('{1'b0, j % 4, 32'hA5A50003});
      end
      req_byte_valid = '1;
      req = '1;
      n = 0;
      for (int c = 0; c < 400 && n < 5; c++) begin
         @(negedge clk);
         if (done_o != '0) n++;
      end
      req = '0;
      req_byte_valid = '0;
      chk("fair_jobs", n, 5);
      @(negedge clk);

      // empty message and single character
      run_job(0, 0, 8'h00, 32'hb4d92c3f, 1'b1, 1'b0, 4);
      run_job(1, 1, 8'h41, 32'h4b76d630, 1'b1, 1'b0, 4);

      // byte gaps on requester 2, length 3
      cur_dig = 32'h0BADF00D;
      for (int j = 0; j < 3; j++) mq.push_back('{gd[j], 64'd3});
      evq.push_back('{1'b0, 2, 32'h0BADF00D});
      last_dig = 32'h0BADF00D;
      set_lane(2, 3, 8'h00);
      req[2] = 1'b1;
      k = 0; t = 1; cyc = 0;
      while (k < 3 && cyc < 100) begin
         req_byte_valid[2] = (t % 2 == 0);
         req_byte[2*8 +: 8] = gd[k];
         #1;
         if (req_byte_ready[2]) k++;
         t++;
         @(negedge clk);
         cyc++;
      end
      req_byte_valid[2] = 1'b0;
      chk("gap_bytes", k, 3);
      wait_fin(2, cyc);
      req[2] = 1'b0;
      @(negedge clk);

      // watchdog abort, digest held
      run_job(0, 1, 8'h55, 32'hDEAD0005, 1'b0, 1'b1, 10);
      chk("abort_idle", grant, 0);
      core_en = 1'b1;

      // reset while FEED stalls on requester 3
      cur_dig = 32'h600D0006;
      set_lane(3, 3, 8'h00);
      req[3] = 1'b1;
      repeat (4) @(negedge clk);
      chk("stall_grant", grant, 4'b1000);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_grant", grant, 0);
      chk("mid_rst_mvalid", core_M_valid, 0);
      chk("mid_rst_done", done_o | err_o, 0);
      chk("mid_rst_digest", digest_o, 0);
      rst_n = 1'b1;
      set_lane(0, 1, 8'h60);
      set_lane(3, 1, 8'h63);
      mq.push_back('{8'h60, 64'd1});
      mq.push_back('{8'h63, 64'd1});
      evq.push_back('{1'b0, 0, 32'h600D0006});
      evq.push_back('{1'b0, 3, 32'h600D0006});
      req_byte_valid = 4'b1001;
      req = 4'b1001;
      n = 0;
      for (int c = 0; c < 200 && n < 2; c++) begin
         @(negedge clk);
         if (done_o != '0) n++;
      end
      req = '0;
      req_byte_valid = '0;
      chk("post_rst_jobs", n, 2);

      repeat (5) @(negedge clk);
      chk("mq_empty", mq.size(), 0);
      chk("evq_empty", evq.size(), 0);
      chk("final_grant", grant, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
